// File: rtl/register_file_mp.sv
// register_file_mp: multi-read, dual-write register file with r0 hardwired to zero, optional write-to-read bypass and a per-register busy scoreboard
module register_file_mp #(
  parameter int XLEN = 32,
  parameter int NREGS = 32,
  parameter int NREAD = 2,
  parameter int BYPASS = 1,
  localparam int AW = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREAD*AW-1:0]   rd_addr,
  output logic [NREAD*XLEN-1:0] rd_data,
  output logic [NREAD-1:0]      rd_busy,
  input  logic                  wr0_en,
  input  logic [AW-1:0]         wr0_addr,
  input  logic [XLEN-1:0]       wr0_data,
  input  logic                  wr1_en,
  input  logic [AW-1:0]         wr1_addr,
  input  logic [XLEN-1:0]       wr1_data,
  input  logic                  iss_en,
  input  logic [AW-1:0]         iss_addr,
  input  logic                  flush,
  output logic                  wr_conflict,
  output logic                  busy_any
);
  logic [XLEN-1:0] mem [NREGS];
  logic [NREGS-1:0] busy, busy_nx;
  logic w0, w1;
  assign w0 = wr0_en && wr0_addr != '0;
  assign w1 = wr1_en && wr1_addr != '0;
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) mem[i] <= '0;
    end else begin
      if (w0) mem[wr0_addr] <= wr0_data;
      if (w1) mem[wr1_addr] <= wr1_data;
    end
  end
  always_comb begin
    busy_nx = '0;
    for (int i = 1; i < NREGS; i++)
      busy_nx[i] = !flush && ((iss_en && iss_addr == AW'(i)) ||
                   (busy[i] && !(wr0_en && wr0_addr == AW'(i)) && !(wr1_en && wr1_addr == AW'(i))));
  end
  always_ff @(posedge clk) begin
    busy        <= reset ? '0 : busy_nx;
    busy_any    <= !reset && |busy_nx;
    wr_conflict <= !reset && w0 && w1 && wr0_addr == wr1_addr;
  end
  for (genvar k = 0; k < NREAD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic h0, h1;
    assign a = rd_addr[k*AW +: AW];
    assign h0 = BYPASS != 0 && w0 && wr0_addr == a;
    assign h1 = BYPASS != 0 && w1 && wr1_addr == a;
    assign rd_data[k*XLEN +: XLEN] = a == '0 ? '0 : h1 ? wr1_data : h0 ? wr0_data : mem[a];
    assign rd_busy[k] = a != '0 && !h0 && !h1 && busy[a];
  end
endmodule

// File: tb/tb_register_file_mp.sv
// tb_register_file_mp: randomized and directed check of register_file_mp (bypass on and off) against a behavioural model
module tb_register_file_mp;
  logic clk = 0, reset = 0;
  logic [9:0] rd_addr = '0;
  logic wr0_en = 0, wr1_en = 0, iss_en = 0, flush = 0;
  logic [4:0] wr0_addr = '0, wr1_addr = '0, iss_addr = '0;
  logic [31:0] wr0_data = '0, wr1_data = '0;
  logic [63:0] rd_data_b, rd_data_n;
  logic [1:0] rd_busy_b, rd_busy_n;
  logic conf_b, conf_n, any_b, any_n;
  logic [31:0] mem [32];
  logic [31:0] bsy;
  logic m_conf, m_any;
  bit chk_en = 0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  register_file_mp #(.BYPASS(1)) dut_b (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .wr_conflict(conf_b), .busy_any(any_b));
  register_file_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
    .iss_en(iss_en), .iss_addr(iss_addr), .flush(flush),
    .wr_conflict(conf_n), .busy_any(any_n));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && wr1_en && wr1_addr == a) return wr1_data;
    if (byp && wr0_en && wr0_addr == a) return wr0_data;
    return mem[a];
  endfunction
  function automatic logic exp_busy(input logic [4:0] a, input bit byp);
    if (a == 0) return 0;
    if (byp && ((wr0_en && wr0_addr == a) || (wr1_en && wr1_addr == a))) return 0;
    return bsy[a];
  endfunction
  task automatic tick();
    #1;
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        check($sformatf("rd_data_byp[%0d]", k), rd_data_b[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5], 1));
        check($sformatf("rd_data_nobyp[%0d]", k), rd_data_n[k*32 +: 32], exp_rd(rd_addr[k*5 +: 5], 0));
        check($sformatf("rd_busy_byp[%0d]", k), 32'(rd_busy_b[k]), 32'(exp_busy(rd_addr[k*5 +: 5], 1)));
        check($sformatf("rd_busy_nobyp[%0d]", k), 32'(rd_busy_n[k]), 32'(exp_busy(rd_addr[k*5 +: 5], 0)));
      end
      check("wr_conflict_byp", 32'(conf_b), 32'(m_conf));
      check("wr_conflict_nobyp", 32'(conf_n), 32'(m_conf));
      check("busy_any_byp", 32'(any_b), 32'(m_any));
      check("busy_any_nobyp", 32'(any_n), 32'(m_any));
    end
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) mem[i] = 0;
      bsy = 0;
      m_conf = 0;
      m_any = 0;
    end else begin
      m_conf = wr0_en && wr1_en && wr0_addr == wr1_addr && wr0_addr != 0;
      if (wr0_en && wr0_addr != 0) mem[wr0_addr] = wr0_data;
      if (wr1_en && wr1_addr != 0) mem[wr1_addr] = wr1_data;
      if (wr0_en) bsy[wr0_addr] = 0;
      if (wr1_en) bsy[wr1_addr] = 0;
      if (iss_en && iss_addr != 0) bsy[iss_addr] = 1;
      if (flush) bsy = 0;
      m_any = |bsy;
    end
    @(negedge clk);
    reset = 0; wr0_en = 0; wr1_en = 0; iss_en = 0; flush = 0;
  endtask
  initial begin
    @(negedge clk);
    reset = 1; tick();
    reset = 1; tick();
    chk_en = 1;
    wr0_en = 1; wr0_addr = 5; wr0_data = 32'hDEADBEEF; tick();
    rd_addr = {5'd5, 5'd5}; #1;
    check("r5_port0", rd_data_b[31:0], 32'hDEADBEEF);
    check("r5_port1", rd_data_b[63:32], 32'hDEADBEEF);
    check("r5_busy", 32'(rd_busy_b), 0);
    tick();
    wr0_en = 1; wr0_addr = 0; wr0_data = 32'h1234; tick();
    rd_addr = {5'd0, 5'd0}; #1;
    check("r0_read", rd_data_b[31:0], 0);
    iss_en = 1; iss_addr = 0; tick();
    #1 check("r0_issue_busy_any", 32'(any_b), 0);
    tick();
    wr0_en = 1; wr0_addr = 7; wr0_data = 32'hAAAA;
    wr1_en = 1; wr1_addr = 7; wr1_data = 32'h5555; tick();
    rd_addr = {5'd7, 5'd7}; #1;
    check("r7_conflict_data", rd_data_n[31:0], 32'h5555);
    check("conflict_pulse", 32'(conf_b), 1);
    tick();
    #1 check("conflict_drop", 32'(conf_b), 0);
    tick();
    wr0_en = 1; wr0_addr = 3; wr0_data = 32'h11; tick();
    wr1_en = 1; wr1_addr = 3; wr1_data = 32'h22; rd_addr = {5'd3, 5'd3}; #1;
    check("bypass_on", rd_data_b[31:0], 32'h22);
    check("bypass_off", rd_data_n[31:0], 32'h11);
    tick();
    iss_en = 1; iss_addr = 9; tick();
    rd_addr = {5'd9, 5'd9}; #1;
    check("r9_busy", 32'(rd_busy_b[0]), 1);
    check("r9_busy_any", 32'(any_b), 1);
    wr0_en = 1; wr0_addr = 9; wr0_data = 32'h99; iss_en = 1; iss_addr = 9; tick();
    #1 check("r9_still_busy", 32'(rd_busy_n[0]), 1);
    flush = 1; tick();
    #1;
    check("flush_rd_busy", 32'(rd_busy_b), 0);
    check("flush_busy_any", 32'(any_b), 0);
    tick();
    for (int i = 1; i < 32; i++) begin
      wr0_en = 1; wr0_addr = 5'(i); wr0_data = i; iss_en = 1; iss_addr = 5'(32 - i); tick();
    end
    rd_addr = {5'd4, 5'd31}; #1;
    check("pre_reset_r31", rd_data_b[31:0], 31);
    reset = 1; wr0_en = 1; wr0_addr = 4; wr0_data = 32'h77; tick();
    #1 check("reset_busy_any", 32'(any_b), 0);
    for (int i = 0; i < 32; i += 2) begin
      rd_addr = {5'(i + 1), 5'(i)}; #1;
      check("post_reset_lo", rd_data_b[31:0], 0);
      check("post_reset_hi", rd_data_n[63:32], 0);
      tick();
    end
    for (int n = 0; n < 2000; n++) begin
      rd_addr = $urandom_range(0, 1) ? 10'($urandom) : {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
      wr0_en = $urandom_range(0, 2) != 0; wr0_addr = 5'($urandom_range(0, 7)); wr0_data = $urandom;
      wr1_en = $urandom_range(0, 2) != 0; wr1_addr = 5'($urandom_range(0, 7)); wr1_data = $urandom;
      iss_en = $urandom_range(0, 1) != 0; iss_addr = 5'($urandom_range(0, 7));
      flush = $urandom_range(0, 19) == 0;
      reset = $urandom_range(0, 49) == 0;
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
